// File: rtl/control_fsm.sv
// control_fsm -- multi-cycle control unit for a small RV32I subset
// (R-type ALU, I-type ALU, LW, SW, BEQ).
//
// Ports:
//   clk, reset          : clock; asynchronous active-high reset
//   opcode/funct3/funct7: instruction fields from the datapath, sampled in DECODE
//   mem_ready           : data memory access complete (looked at only in MEM)
//   ALU_op              : 0 ADD,1 SUB,2 AND,3 OR,4 XOR,5 SLL,6 SRL,7 SRA,8 SLT
//   RegWrite, MemRead, MemWrite, ALUsrc, MemtoReg, branch : datapath controls
//   ImmSel              : 00 I-type, 01 S-type, 10 B-type
//   pc_write, ir_write  : PC / instruction register load enables
//   illegal             : sticky trap flag (high while in TRAP)
//   state               : FSM state, FETCH=0 DECODE=1 EXEC=2 MEM=3 WB=4 TRAP=5
//   instr_count         : retired instruction counter, wraps at 16 bits
//
// Handshake: there is no valid/ready pair here; MEM simply holds its strobe
// (MemRead or MemWrite) every cycle until the cycle in which mem_ready=1, and
// that cycle completes the access.
module control_fsm (
  input  logic        clk,
  input  logic        reset,
  input  logic [6:0]  opcode,
  input  logic [2:0]  funct3,
  input  logic [6:0]  funct7,
  input  logic        mem_ready,
  output logic [3:0]  ALU_op,
  output logic        RegWrite,
  output logic        MemRead,
  output logic        MemWrite,
  output logic        ALUsrc,
  output logic        MemtoReg,
  output logic        branch,
  output logic [1:0]  ImmSel,
  output logic        pc_write,
  output logic        ir_write,
  output logic        illegal,
  output logic [2:0]  state,
  output logic [15:0] instr_count
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd5
  } state_t;

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;

  localparam logic [3:0] ALU_ADD = 4'd0;
  localparam logic [3:0] ALU_SUB = 4'd1;
  localparam logic [3:0] ALU_AND = 4'd2;
  localparam logic [3:0] ALU_OR  = 4'd3;
  localparam logic [3:0] ALU_XOR = 4'd4;
  localparam logic [3:0] ALU_SLL = 4'd5;
  localparam logic [3:0] ALU_SRL = 4'd6;
  localparam logic [3:0] ALU_SRA = 4'd7;
  localparam logic [3:0] ALU_SLT = 4'd8;

  state_t      state_q, state_d;
  logic [6:0]  op_q, f7_q;
  logic [2:0]  f3_q;
  logic [15:0] count_q;
  logic        retire;

  // Decode reads the live fields while in DECODE (to choose TRAP vs EXEC)
  // and the latched copy everywhere else.
  logic [6:0]  dec_op, dec_f7;
  logic [2:0]  dec_f3;
  logic [3:0]  dec_alu;
  logic        dec_illegal;
  logic        is_r, f7_zero, f7_alt;

  assign dec_op = (state_q == S_DECODE) ? opcode : op_q;
  assign dec_f3 = (state_q == S_DECODE) ? funct3 : f3_q;
  assign dec_f7 = (state_q == S_DECODE) ? funct7 : f7_q;

  assign is_r    = (dec_op == OP_R);
  assign f7_zero = (dec_f7 == 7'b0000000);
  assign f7_alt  = (dec_f7 == 7'b0100000);

  always_comb begin
    dec_alu     = ALU_ADD;
    dec_illegal = 1'b0;
    case (dec_op)
      OP_R, OP_I: begin
        // funct7 matters for every R-type op, but for I-type only on shifts.
        case (dec_f3)
          3'b000: begin
            if (is_r && f7_alt)            dec_alu = ALU_SUB;
            else if (is_r && !f7_zero)     dec_illegal = 1'b1;
          end
          3'b111: begin dec_alu = ALU_AND; dec_illegal = is_r && !f7_zero; end
          3'b110: begin dec_alu = ALU_OR;  dec_illegal = is_r && !f7_zero; end
          3'b100: begin dec_alu = ALU_XOR; dec_illegal = is_r && !f7_zero; end
          3'b010: begin dec_alu = ALU_SLT; dec_illegal = is_r && !f7_zero; end
          3'b001: begin dec_alu = ALU_SLL; dec_illegal = !f7_zero; end
          3'b101: begin
            if (f7_zero)     dec_alu = ALU_SRL;
            else if (f7_alt) dec_alu = ALU_SRA;
            else             dec_illegal = 1'b1;
          end
          default: dec_illegal = 1'b1;
        endcase
      end
      OP_LW, OP_SW, OP_BEQ: dec_illegal = 1'b0;
      default:              dec_illegal = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_FETCH;
      op_q    <= 7'd0;
      f3_q    <= 3'd0;
      f7_q    <= 7'd0;
      count_q <= 16'd0;
    end else begin
      state_q <= state_d;
      if (state_q == S_DECODE) begin
        op_q <= opcode;
        f3_q <= funct3;
        f7_q <= funct7;
      end
      if (retire) count_q <= count_q + 16'd1;
    end
  end

  always_comb begin
    state_d  = state_q;
    ALU_op   = ALU_ADD;
    RegWrite = 1'b0;
    MemRead  = 1'b0;
    MemWrite = 1'b0;
    ALUsrc   = 1'b0;
    MemtoReg = 1'b0;
    branch   = 1'b0;
    ImmSel   = 2'b00;
    pc_write = 1'b0;
    ir_write = 1'b0;
    retire   = 1'b0;
    case (state_q)
      S_FETCH: begin
        ir_write = 1'b1;
        state_d  = S_DECODE;
      end
      S_DECODE: state_d = dec_illegal ? S_TRAP : S_EXEC;
      S_EXEC: begin
        case (op_q)
          OP_LW, OP_SW: begin
            ALUsrc  = 1'b1;
            ImmSel  = (op_q == OP_SW) ? 2'b01 : 2'b00;
            state_d = S_MEM;
          end
          OP_BEQ: begin
            ALU_op   = ALU_SUB;
            ImmSel   = 2'b10;
            branch   = 1'b1;
            pc_write = 1'b1;
            retire   = 1'b1;
            state_d  = S_FETCH;
          end
          default: begin
            // Only legal R/I ALU ops can reach EXEC here.
            ALU_op  = dec_alu;
            ALUsrc  = (op_q == OP_I);
            state_d = S_WB;
          end
        endcase
      end
      S_MEM: begin
        // Address-generation controls stay stable for the whole wait.
        ALUsrc   = 1'b1;
        ImmSel   = (op_q == OP_SW) ? 2'b01 : 2'b00;
        MemRead  = (op_q == OP_LW);
        MemWrite = (op_q == OP_SW);
        if (mem_ready) begin
          if (op_q == OP_SW) begin
            pc_write = 1'b1;
            retire   = 1'b1;
            state_d  = S_FETCH;
          end else begin
            state_d  = S_WB;
          end
        end
      end
      S_WB: begin
        ALU_op   = (op_q == OP_LW) ? ALU_ADD : dec_alu;
        ALUsrc   = (op_q != OP_R);
        RegWrite = 1'b1;
        MemtoReg = (op_q == OP_LW);
        pc_write = 1'b1;
        retire   = 1'b1;
        state_d  = S_FETCH;
      end
      S_TRAP:  state_d = S_TRAP;
      default: state_d = S_FETCH;
    endcase
  end

  assign illegal     = (state_q == S_TRAP);
  assign state       = state_q;
  assign instr_count = count_q;

endmodule

// File: tb/tb_control_fsm.sv
// tb_control_fsm -- self-checking bench for control_fsm.
// Each instruction pushes its expected per-cycle output vectors (and the
// mem_ready value to drive in that cycle) into queues; the test task then
// plays the cycles and compares the DUT against the popped expectation.
module tb_control_fsm;

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;

  logic        clk = 1'b0;
  logic        reset;
  logic [6:0]  opcode, funct7;
  logic [2:0]  funct3;
  logic        mem_ready;
  logic [3:0]  ALU_op;
  logic        RegWrite, MemRead, MemWrite, ALUsrc, MemtoReg, branch;
  logic [1:0]  ImmSel;
  logic        pc_write, ir_write, illegal;
  logic [2:0]  state;
  logic [15:0] instr_count;

  control_fsm dut (
    .clk(clk), .reset(reset), .opcode(opcode), .funct3(funct3), .funct7(funct7),
    .mem_ready(mem_ready), .ALU_op(ALU_op), .RegWrite(RegWrite), .MemRead(MemRead),
    .MemWrite(MemWrite), .ALUsrc(ALUsrc), .MemtoReg(MemtoReg), .branch(branch),
    .ImmSel(ImmSel), .pc_write(pc_write), .ir_write(ir_write), .illegal(illegal),
    .state(state), .instr_count(instr_count)
  );

  // clock
  always #5 clk = ~clk;

  // scoreboard
  logic [17:0] exp_q[$];
  logic        mr_q[$];
  logic [17:0] exp_v;
  logic [15:0] exp_count;
  int          tests_run = 0;
  int          failed = 0;
  int          cyc;

  // Vector: {state, ALU_op, RegWrite, MemRead, MemWrite, ALUsrc, MemtoReg,
  //          branch, ImmSel, pc_write, ir_write, illegal}
  function automatic logic [17:0] vec(input logic [2:0] st, input logic [3:0] alu,
                                      input logic [5:0] fl, input logic [1:0] imm,
                                      input logic pcw, input logic irw, input logic ill);
    return {st, alu, fl, imm, pcw, irw, ill};
  endfunction

  function automatic logic [17:0] obs();
    return {state, ALU_op, RegWrite, MemRead, MemWrite, ALUsrc, MemtoReg, branch,
            ImmSel, pc_write, ir_write, illegal};
  endfunction

  function automatic logic rnd_bit();
    return 1'($urandom_range(0, 1));
  endfunction

  localparam logic [17:0] V_FETCH  = {3'd0, 4'd0, 6'b0, 2'b00, 1'b0, 1'b1, 1'b0};
  localparam logic [17:0] V_DECODE = {3'd1, 4'd0, 6'b0, 2'b00, 1'b0, 1'b0, 1'b0};
  localparam logic [17:0] V_TRAP   = {3'd5, 4'd0, 6'b0, 2'b00, 1'b0, 1'b0, 1'b1};

  // driver tasks
  task automatic push_exp(input logic [17:0] v, input logic mr);
    exp_q.push_back(v);
    mr_q.push_back(mr);
  endtask

  task automatic push_front_end();
    push_exp(V_FETCH, rnd_bit());
    push_exp(V_DECODE, rnd_bit());
  endtask

  task automatic push_alu(input logic [3:0] alu, input logic is_i);
    push_front_end();
    push_exp(vec(3'd2, alu, {3'b000, is_i, 2'b00}, 2'b00, 1'b0, 1'b0, 1'b0), rnd_bit());
    push_exp(vec(3'd4, alu, {3'b100, is_i, 2'b00}, 2'b00, 1'b1, 1'b0, 1'b0), rnd_bit());
    exp_count++;
  endtask

  task automatic push_lw(input int waits);
    push_front_end();
    push_exp(vec(3'd2, 4'd0, 6'b000100, 2'b00, 1'b0, 1'b0, 1'b0), rnd_bit());
    for (int w = 0; w < waits; w++)
      push_exp(vec(3'd3, 4'd0, 6'b010100, 2'b00, 1'b0, 1'b0, 1'b0), 1'b0);
    push_exp(vec(3'd3, 4'd0, 6'b010100, 2'b00, 1'b0, 1'b0, 1'b0), 1'b1);
    push_exp(vec(3'd4, 4'd0, 6'b100110, 2'b00, 1'b1, 1'b0, 1'b0), rnd_bit());
    exp_count++;
  endtask

  task automatic push_sw(input int waits);
    push_front_end();
    push_exp(vec(3'd2, 4'd0, 6'b000100, 2'b01, 1'b0, 1'b0, 1'b0), rnd_bit());
    for (int w = 0; w < waits; w++)
      push_exp(vec(3'd3, 4'd0, 6'b001100, 2'b01, 1'b0, 1'b0, 1'b0), 1'b0);
    push_exp(vec(3'd3, 4'd0, 6'b001100, 2'b01, 1'b1, 1'b0, 1'b0), 1'b1);
    exp_count++;
  endtask

  task automatic push_beq();
    push_front_end();
    push_exp(vec(3'd2, 4'd1, 6'b000001, 2'b10, 1'b1, 1'b0, 1'b0), rnd_bit());
    exp_count++;
  endtask

  task automatic push_trap(input int n);
    push_front_end();
    for (int i = 0; i < n; i++) push_exp(V_TRAP, rnd_bit());
  endtask

  task automatic load_instr(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7);
    opcode = op;
    funct3 = f3;
    funct7 = f7;
    cyc    = 0;
  endtask

  // Applies this cycle's mem_ready; from EXEC on the instruction fields are
  // scrambled so only the values captured in DECODE can steer the FSM.
  task automatic drive_cycle();
    mem_ready = mr_q.pop_front();
    if (cyc >= 2) begin
      opcode = 7'($urandom);
      funct3 = 3'($urandom);
      funct7 = 7'($urandom);
    end
    cyc++;
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; mem_ready = 1'b0;
    load_instr(7'd0, 3'd0, 7'd0);
    exp_count = 16'd0;
    @(negedge clk); @(negedge clk); #1;
    tests_run++;
    if (obs() !== V_FETCH) begin
      failed++; $display("FAIL reset_outputs: got %h, required %h", obs(), V_FETCH);
    end
    tests_run++;
    if (instr_count !== 16'd0) begin
      failed++; $display("FAIL reset_count: got %h, required 0000", instr_count);
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  logic [21:0] alu_tbl [0:13] = '{
    {OP_R, 3'b000, 7'h00, 4'd0, 1'b0}, {OP_R, 3'b000, 7'h20, 4'd1, 1'b0},
    {OP_R, 3'b111, 7'h00, 4'd2, 1'b0}, {OP_R, 3'b110, 7'h00, 4'd3, 1'b0},
    {OP_R, 3'b100, 7'h00, 4'd4, 1'b0}, {OP_R, 3'b001, 7'h00, 4'd5, 1'b0},
    {OP_R, 3'b101, 7'h00, 4'd6, 1'b0}, {OP_R, 3'b101, 7'h20, 4'd7, 1'b0},
    {OP_R, 3'b010, 7'h00, 4'd8, 1'b0}, {OP_I, 3'b000, 7'h20, 4'd0, 1'b1},
    {OP_I, 3'b101, 7'h20, 4'd7, 1'b1}, {OP_I, 3'b111, 7'h7f, 4'd2, 1'b1},
    {OP_I, 3'b010, 7'h55, 4'd8, 1'b1}, {OP_I, 3'b001, 7'h00, 4'd5, 1'b1}
  };

  task automatic test_alu();
    logic [6:0] op, f7; logic [2:0] f3; logic [3:0] alu; logic is_i;
    for (int k = 0; k < 14; k++) begin
      {op, f3, f7, alu, is_i} = alu_tbl[k];
      load_instr(op, f3, f7);
      push_alu(alu, is_i);
      while (exp_q.size() != 0) begin
        drive_cycle();
        exp_v = exp_q.pop_front();
        tests_run++;
        if (obs() !== exp_v) begin
          failed++; $display("FAIL alu[%0d] cycle %0d: got %h, required %h", k, cyc - 1, obs(), exp_v);
        end
        @(negedge clk);
      end
      tests_run++;
      if (instr_count !== exp_count) begin
        failed++; $display("FAIL alu[%0d]_count: got %h, required %h", k, instr_count, exp_count);
      end
    end
  endtask

  task automatic test_mem();
    int waits [4] = '{2, 0, 0, 3};
    for (int k = 0; k < 4; k++) begin
      if (k < 2) begin load_instr(OP_LW, 3'b010, 7'h00); push_lw(waits[k]); end
      else       begin load_instr(OP_SW, 3'b010, 7'h00); push_sw(waits[k]); end
      while (exp_q.size() != 0) begin
        drive_cycle();
        exp_v = exp_q.pop_front();
        tests_run++;
        if (obs() !== exp_v) begin
          failed++; $display("FAIL mem[%0d] cycle %0d: got %h, required %h", k, cyc - 1, obs(), exp_v);
        end
        @(negedge clk);
      end
      tests_run++;
      if (instr_count !== exp_count) begin
        failed++; $display("FAIL mem[%0d]_count: got %h, required %h", k, instr_count, exp_count);
      end
    end
  endtask

  task automatic test_beq();
    load_instr(OP_BEQ, 3'b000, 7'h00);
    push_beq();
    while (exp_q.size() != 0) begin
      drive_cycle();
      exp_v = exp_q.pop_front();
      tests_run++;
      if (obs() !== exp_v) begin
        failed++; $display("FAIL beq cycle %0d: got %h, required %h", cyc - 1, obs(), exp_v);
      end
      @(negedge clk);
    end
    // Back in FETCH right after the three BEQ cycles.
    tests_run++;
    if (state !== 3'd0 || instr_count !== exp_count) begin
      failed++; $display("FAIL beq_return: got state %0d count %h, required state 0 count %h",
                         state, instr_count, exp_count);
    end
  endtask

  task automatic test_back_to_back();
    int kind;
    for (int k = 0; k < 8; k++) begin
      kind = $urandom_range(0, 3);
      case (kind)
        0: begin load_instr(OP_LW, 3'b010, 7'h00); push_lw($urandom_range(0, 3)); end
        1: begin load_instr(OP_SW, 3'b010, 7'h00); push_sw($urandom_range(0, 3)); end
        2: begin load_instr(OP_I, 3'b100, 7'h3c); push_alu(4'd4, 1'b1); end
        default: begin load_instr(OP_BEQ, 3'b000, 7'h00); push_beq(); end
      endcase
      while (exp_q.size() != 0) begin
        drive_cycle();
        exp_v = exp_q.pop_front();
        tests_run++;
        if (obs() !== exp_v) begin
          failed++; $display("FAIL b2b[%0d] kind %0d cycle %0d: got %h, required %h",
                             k, kind, cyc - 1, obs(), exp_v);
        end
        @(negedge clk);
      end
    end
    tests_run++;
    if (instr_count !== exp_count) begin
      failed++; $display("FAIL b2b_count: got %h, required %h", instr_count, exp_count);
    end
  endtask

  task automatic test_wrap();
    force dut.count_q = 16'hFFFE;
    #1;
    release dut.count_q;
    exp_count = 16'hFFFE;
    tests_run++;
    if (instr_count !== exp_count) begin
      failed++; $display("FAIL wrap_preload: got %h, required %h", instr_count, exp_count);
    end
    for (int k = 0; k < 2; k++) begin
      load_instr(OP_BEQ, 3'b000, 7'h00);
      push_beq();
      while (exp_q.size() != 0) begin
        drive_cycle();
        exp_v = exp_q.pop_front();
        tests_run++;
        if (obs() !== exp_v) begin
          failed++; $display("FAIL wrap[%0d] cycle %0d: got %h, required %h", k, cyc - 1, obs(), exp_v);
        end
        @(negedge clk);
      end
      tests_run++;
      if (instr_count !== exp_count) begin
        failed++; $display("FAIL wrap[%0d]_count: got %h, required %h", k, instr_count, exp_count);
      end
    end
  endtask

  logic [16:0] ill_tbl [0:2] = '{
    {7'b1111111, 3'b000, 7'h00}, {OP_R, 3'b111, 7'h20}, {OP_I, 3'b011, 7'h00}
  };

  task automatic test_illegal();
    logic [6:0] op, f7; logic [2:0] f3;
    for (int k = 0; k < 3; k++) begin
      {op, f3, f7} = ill_tbl[k];
      load_instr(op, f3, f7);
      push_trap(4);
      while (exp_q.size() != 0) begin
        drive_cycle();
        exp_v = exp_q.pop_front();
        tests_run++;
        if (obs() !== exp_v) begin
          failed++; $display("FAIL illegal[%0d] cycle %0d: got %h, required %h", k, cyc - 1, obs(), exp_v);
        end
        @(negedge clk);
      end
      // Reset is the only way out of TRAP; it also clears the counter.
      reset = 1'b1;
      exp_count = 16'd0;
      #1;
      tests_run++;
      if (obs() !== V_FETCH || instr_count !== exp_count) begin
        failed++; $display("FAIL illegal[%0d]_reset: got %h count %h, required %h count %h",
                           k, obs(), instr_count, V_FETCH, exp_count);
      end
      @(negedge clk);
      reset = 1'b0;
    end
  endtask

  task automatic test_reset_in_mem();
    load_instr(OP_LW, 3'b010, 7'h00);
    push_front_end();
    push_exp(vec(3'd2, 4'd0, 6'b000100, 2'b00, 1'b0, 1'b0, 1'b0), rnd_bit());
    push_exp(vec(3'd3, 4'd0, 6'b010100, 2'b00, 1'b0, 1'b0, 1'b0), 1'b0);
    push_exp(vec(3'd3, 4'd0, 6'b010100, 2'b00, 1'b0, 1'b0, 1'b0), 1'b0);
    while (exp_q.size() != 0) begin
      drive_cycle();
      exp_v = exp_q.pop_front();
      tests_run++;
      if (obs() !== exp_v) begin
        failed++; $display("FAIL rst_mem cycle %0d: got %h, required %h", cyc - 1, obs(), exp_v);
      end
      @(negedge clk);
    end
    // Still waiting in MEM; assert reset between clock edges.
    mem_ready = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    tests_run++;
    if (obs() !== V_FETCH || instr_count !== exp_count) begin
      failed++; $display("FAIL rst_mem_abort: got %h count %h, required %h count %h",
                         obs(), instr_count, V_FETCH, exp_count);
    end
    @(negedge clk);
    reset = 1'b0;
    load_instr(OP_R, 3'b000, 7'h00);
    push_alu(4'd0, 1'b0);
    while (exp_q.size() != 0) begin
      drive_cycle();
      exp_v = exp_q.pop_front();
      tests_run++;
      if (obs() !== exp_v) begin
        failed++; $display("FAIL rst_mem_after cycle %0d: got %h, required %h", cyc - 1, obs(), exp_v);
      end
      @(negedge clk);
    end
    tests_run++;
    if (instr_count !== exp_count) begin
      failed++; $display("FAIL rst_mem_count: got %h, required %h", instr_count, exp_count);
    end
  endtask

  initial begin
    test_reset();
    test_alu();
    test_mem();
    test_beq();
    test_back_to_back();
    test_wrap();
    test_illegal();
    test_reset_in_mem();
    $display("[TB] %0d tests run, %0d failed", tests_run, failed);
    $finish;
  end

endmodule
